fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Multi-cycle front end. Fetches one 32-bit word from instruction memory (req/ready handshake) into the
//  instruction register and drives instruction_decoder from it. Consumes the decoder's cnt_set/ins_JAL/IM,
//  issues exec_step strobes to the datapath, then advances PC by +4 or by the JAL offset.
//  One instruction in flight; no pipelining.
// PARAMETERS
//  RESET_PC      32'h0000_0000  PC loaded on reset
//  FETCH_TIMEOUT 16             max wait cycles for imem_ready before fetch_err (>=1)
// PORTS
//  clk          in   1   single clock, rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  imem_req     out  1   fetch request, held until accepted
//  imem_addr    out  32  fetch address (= pc), stable while imem_req=1
//  imem_ready   in   1   memory accepts and returns data this cycle when imem_req=1
//  imem_rdata   in   32  instruction word, valid when imem_req&&imem_ready
//  instruction  out  32  instruction register, to decoder
//  cnt_set      in   2   from decoder: execute cycles needed (0 = not a legal instruction)
//  ins_JAL      in   1   from decoder
//  IM           in   32  from decoder; for JAL, IM[19:0] = offset[20:1]
//  exec_en      out  1   datapath performs step exec_step this cycle
//  exec_step    out  2   current execute step, 0..cnt_set-1
//  pc           out  32  address of the instruction in IR (JAL link = pc+4)
//  illegal_insn out  1   one-cycle pulse: cnt_set==0 at DECODE
//  fetch_err    out  1   sticky; set on fetch timeout, cleared only by reset
// BEHAVIOUR
//  Reset (async assert, sync-released use): state=FETCH, pc=RESET_PC, instruction=0, imem_req=0,
//   exec_en=0, exec_step=0, illegal_insn=0, fetch_err=0, wait counter=0.
//  States: FETCH -> WAIT -> DECODE -> EXEC -> UPDATE -> FETCH; HALT terminal.
//  FETCH: assert imem_req, imem_addr=pc, wait_cnt=0; go WAIT next cycle.
//  WAIT: imem_req=1. On imem_ready: instruction<=imem_rdata, imem_req<=0, -> DECODE.
//   Else wait_cnt++; at wait_cnt==FETCH_TIMEOUT-1 without ready: fetch_err<=1, imem_req<=0, -> HALT.
//   ready in same cycle as timeout wins (data taken, no error).
//  DECODE: one cycle for decoder comb settle. cnt_set==0: illegal_insn pulse, -> UPDATE (PC+4,
//   no exec_en). Else latch n=cnt_set, exec_step=0, -> EXEC.
//  EXEC: exec_en=1 for exactly n consecutive cycles, exec_step 0,1,..n-1; -> UPDATE after step n-1.
//   cnt_set/IM sampled in DECODE and UPDATE only; IR is stable through EXEC.
//  UPDATE: ins_JAL: pc <= pc + {{11{IM[19]}},IM[19:0],1'b0}; else pc <= pc+4. -> FETCH.
//   Arithmetic mod 2^32: wrap 32'hFFFF_FFFC+4 -> 0 silently.
//  Instruction latency (ready immediate): 1 FETCH + 1 WAIT + 1 DECODE + n EXEC + 1 UPDATE = n+4 cycles.
//  HALT: all outputs hold, imem_req=0, exec_en=0; only reset exits.
//  Reset mid-fetch/mid-exec: immediate abort, no partial PC update, imem_req drops asynchronously.
//  Misaligned JAL target (bit1 set) is not trapped; pc[1:0] driven as computed.
// STRUCTURE
//  Shared package/include (alongside INSTRUCTIONS.v): state encodings FS_FETCH..FS_HALT (3 bit),
//   PC_INC=32'd4, JAL offset field width 20.
//  One natural sub-module: pc_next_calc (comb: pc, ins_JAL, IM -> next pc). FSM, IR, wait counter
//   and step counter stay in this module.
// TESTING
//  ADD (cnt_set=1), ready immediate, RESET_PC=0 -> exec_en 1 cycle step0, pc=4 after 5 cycles.
//  LW with cnt_set=3 -> exec_step 0,1,2 on consecutive cycles, exec_en low before/after.
//  JAL at pc=0x100, IM[19:0]=0xFFFF8 (offset -16) -> next imem_addr=0x0F0.
//  Word 0x0000_0000 (cnt_set=0) -> illegal_insn single pulse, no exec_en, next pc=pc+4.
//  imem_ready held low, FETCH_TIMEOUT=16 -> fetch_err=1 after 16 WAIT cycles, imem_req=0, stuck.
//  rst_n low during EXEC step1 -> outputs at reset values that cycle, refetch from RESET_PC on release.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the multi-cycle fetch front end: FSM state
// encodings, the PC increment and the JAL offset field geometry.
package fetch_sequencer_pkg;

  typedef enum logic [2:0] {
    FS_FETCH  = 3'd0,
    FS_WAIT   = 3'd1,
    FS_DECODE = 3'd2,
    FS_EXEC   = 3'd3,
    FS_UPDATE = 3'd4,
    FS_HALT   = 3'd5
  } fs_state_e;

  localparam logic [31:0] PC_INC    = 32'd4;
  localparam int          JAL_OFF_W = 20;

  // The decoder hands over offset[20:1]; rebuild the byte offset with the
  // implicit zero LSB and sign-extend it to 32 bits.
  function automatic logic [31:0] jal_offset(input logic [JAL_OFF_W-1:0] field);
    return {{(32-JAL_OFF_W-1){field[JAL_OFF_W-1]}}, field, 1'b0};
  endfunction

endpackage

// File: rtl/fetch_sequencer_pc_next_calc.sv
// Next-PC computation: sequential +4 or PC-relative JAL target.
// Arithmetic is modulo 2^32; misaligned targets are passed through untouched.
module fetch_sequencer_pc_next_calc
  import fetch_sequencer_pkg::*;
(
  input  logic [31:0]          pc,
  input  logic                 ins_jal,
  input  logic [JAL_OFF_W-1:0] jal_field,
  output logic [31:0]          pc_next
);

  // Select between fall-through and jump target.
  always_comb begin
    if (ins_jal) pc_next = pc + jal_offset(jal_field);
    else         pc_next = pc + PC_INC;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle instruction front end. Fetches one word over a req/ready
// handshake into the instruction register, lets the external decoder settle,
// strobes exec_en for the number of steps the decoder asks for, then moves
// the PC on. Exactly one instruction is in flight at any time.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  input  logic [1:0]  cnt_set,
  input  logic        ins_JAL,
  input  logic [31:0] IM,
  output logic        exec_en,
  output logic [1:0]  exec_step,
  output logic [31:0] pc,
  output logic        illegal_insn,
  output logic        fetch_err
);

  localparam int WAIT_W = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(FETCH_TIMEOUT - 1);

  fs_state_e         state;
  fs_state_e         state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [1:0]        n_lat;
  logic [1:0]        step;
  logic [31:0]       pc_next;
  logic              load_ir;
  logic              set_err;

  // Only the JAL offset field of the immediate is meaningful here.
  logic unused_im;
  assign unused_im = ^IM[31:JAL_OFF_W];

  fetch_sequencer_pc_next_calc u_pc_next (
    .pc        (pc),
    .ins_jal   (ins_JAL),
    .jal_field (IM[JAL_OFF_W-1:0]),
    .pc_next   (pc_next)
  );

  assign imem_addr    = pc;
  assign exec_en      = (state == FS_EXEC);
  assign exec_step    = step;
  assign illegal_insn = (state == FS_DECODE) && (cnt_set == 2'd0);

  // State register.
  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values; blocking = here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FS_FETCH;
    else        state <= state_next;
  end

  // Next-state decode plus the WAIT-state data/error strobes.
  // NOTE: every signal gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    load_ir    = 1'b0;
    set_err    = 1'b0;
    case (state)
      FS_FETCH:  state_next = FS_WAIT;
      FS_WAIT: begin
        // Ready on the last permitted cycle still wins over the timeout.
        if (imem_ready) begin
          load_ir    = 1'b1;
          state_next = FS_DECODE;
        end else if (wait_cnt == WAIT_LAST) begin
          set_err    = 1'b1;
          state_next = FS_HALT;
        end
      end
      FS_DECODE: state_next = (cnt_set == 2'd0) ? FS_UPDATE : FS_EXEC;
      FS_EXEC:   if (step == n_lat - 2'd1) state_next = FS_UPDATE;
      FS_UPDATE: state_next = FS_FETCH;
      FS_HALT:   state_next = FS_HALT;
      default:   state_next = FS_FETCH;
    endcase
  end

  // Datapath registers: PC, instruction register, request, counters, error.
  // NOTE: the instruction register is a plain flop, not a memory array, so it
  // is reset along with the rest of the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      instruction <= 32'd0;
      imem_req    <= 1'b0;
      wait_cnt    <= '0;
      n_lat       <= 2'd0;
      step        <= 2'd0;
      fetch_err   <= 1'b0;
    end else begin
      case (state)
        FS_FETCH: begin
          imem_req <= 1'b1;
          wait_cnt <= '0;
        end
        FS_WAIT: begin
          if (load_ir) begin
            instruction <= imem_rdata;
            imem_req    <= 1'b0;
          end else if (set_err) begin
            fetch_err <= 1'b1;
            imem_req  <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        FS_DECODE: begin
          n_lat <= cnt_set;
          step  <= 2'd0;
        end
        FS_EXEC: begin
          if (state_next == FS_EXEC) step <= step + 2'd1;
        end
        FS_UPDATE: pc <= pc_next;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a small instruction memory and
// decoder model, scoreboards for fetch addresses, execute steps and illegal
// pulses, plus directed checks for reset, timeout and mid-execute reset.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [1:0]  cnt_set;
  logic        ins_JAL;
  logic [31:0] IM;
  logic        exec_en;
  logic [1:0]  exec_step;
  logic [31:0] pc;
  logic        illegal_insn;
  logic        fetch_err;

  always #5 clk = ~clk;

  fetch_sequencer #(.RESET_PC(32'h0000_0000), .FETCH_TIMEOUT(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .instruction  (instruction),
    .cnt_set      (cnt_set),
    .ins_JAL      (ins_JAL),
    .IM           (IM),
    .exec_en      (exec_en),
    .exec_step    (exec_step),
    .pc           (pc),
    .illegal_insn (illegal_insn),
    .fetch_err    (fetch_err)
  );

  // Instruction memory model: 256 words, indexed by address bits [9:2].
  logic [31:0] mem [256];
  assign imem_rdata = mem[imem_addr[9:2]];

  // Decoder model: ADD (opcode 0x33) one step, LW (0x03) three steps,
  // JAL (0x6F) one step with offset[20:1] unscrambled into IM[19:0].
  always_comb begin
    cnt_set = 2'd0;
    ins_JAL = 1'b0;
    IM      = 32'd0;
    case (instruction[6:0])
      7'h33: cnt_set = 2'd1;
      7'h03: cnt_set = 2'd3;
      7'h6F: begin
        cnt_set = 2'd1;
        ins_JAL = 1'b1;
        IM      = {{12{instruction[31]}}, instruction[31], instruction[19:12],
                   instruction[20], instruction[30:21]};
      end
      default: ;
    endcase
  end

  function automatic logic [31:0] jal_word(input int off);
    logic [20:0] o;
    o = off[20:0];
    return {o[20], o[10:1], o[11], o[19:12], 5'd1, 7'h6F};
  endfunction

  int tests = 0;
  int fails = 0;

  logic [31:0] fetch_q [$];
  logic [1:0]  exec_q  [$];
  logic [31:0] ill_q   [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (imem_req && imem_ready) begin
        if (fetch_q.size() == 0) check("fetch_unexpected", 32'(fetch_q.size()), 32'd1);
        else                     check("fetch_addr", imem_addr, fetch_q.pop_front());
      end
      if (exec_en) begin
        if (exec_q.size() == 0) check("exec_unexpected", 32'(exec_q.size()), 32'd1);
        else                    check("exec_step", 32'(exec_step), 32'(exec_q.pop_front()));
      end
      if (illegal_insn) begin
        if (ill_q.size() == 0) check("illegal_unexpected", 32'(ill_q.size()), 32'd1);
        else                   check("illegal_pc", pc, ill_q.pop_front());
      end
    end
  end

  logic found;
  int   cnt;

  initial begin
    rst_n      = 1'b0;
    imem_ready = 1'b1;
    foreach (mem[i]) mem[i] = 32'd0;
    mem[0]   = 32'h0000_0033;   // 0x000 ADD
    mem[1]   = 32'h0000_2003;   // 0x004 LW
    mem[2]   = jal_word(248);   // 0x008 JAL -> 0x100
    mem[64]  = jal_word(-16);   // 0x100 JAL -> 0x0F0
    mem[60]  = 32'h0000_0000;   // 0x0F0 illegal
    mem[61]  = jal_word(-248);  // 0x0F4 JAL -> 0xFFFF_FFFC
    mem[255] = 32'h0000_0033;   // 0xFFFF_FFFC ADD, wraps to 0

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_exec_en", 32'(exec_en), 32'd0);
    check("rst_exec_step", 32'(exec_step), 32'd0);
    check("rst_pc", pc, 32'd0);
    check("rst_instruction", instruction, 32'd0);
    check("rst_illegal", 32'(illegal_insn), 32'd0);
    check("rst_fetch_err", 32'(fetch_err), 32'd0);

    // Program walk: expected fetch addresses, execute steps, illegal PCs.
    fetch_q = '{32'h0, 32'h4, 32'h8, 32'h100, 32'hF0, 32'hF4, 32'hFFFF_FFFC, 32'h0, 32'h4};
    exec_q  = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
    ill_q   = '{32'hF0};
    rst_n = 1'b1;

    // ADD takes 5 cycles with an immediate ready.
    repeat (4) @(negedge clk);
    check("pc_before_update", pc, 32'd0);
    @(negedge clk);
    check("pc_after_add", pc, 32'd4);

    // Run until the second LW reaches step 1, then reset mid-execute.
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk); #1;
      if (exec_en && exec_step == 2'd1 && pc == 32'd4 && fetch_q.size() == 0) found = 1'b1;
    end
    check("reset_trigger_seen", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midexec_rst_exec_en", 32'(exec_en), 32'd0);
    check("midexec_rst_exec_step", 32'(exec_step), 32'd0);
    check("midexec_rst_pc", pc, 32'd0);
    check("midexec_rst_imem_req", 32'(imem_req), 32'd0);
    check("midexec_rst_instruction", instruction, 32'd0);
    check("exec_q_drained", 32'(exec_q.size()), 32'd0);
    check("ill_q_drained", 32'(ill_q.size()), 32'd0);

    // Refetch from RESET_PC; ready arrives on the 16th WAIT cycle and wins.
    @(negedge clk);
    imem_ready = 1'b0;
    fetch_q.push_back(32'h0);
    exec_q.push_back(2'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("refetch_req", 32'(imem_req), 32'd1);
    check("refetch_addr", imem_addr, 32'd0);
    repeat (15) @(posedge clk); #1;
    check("last_wait_req", 32'(imem_req), 32'd1);
    check("last_wait_no_err", 32'(fetch_err), 32'd0);
    imem_ready = 1'b1;
    @(posedge clk); #1;
    check("ready_wins_no_err", 32'(fetch_err), 32'd0);
    check("ready_wins_ir", instruction, 32'h0000_0033);
    imem_ready = 1'b0;

    // Fetch at 0x004 never gets ready: 16 WAIT cycles, then HALT.
    for (int i = 0; i < 50 && !imem_req; i++) begin
      @(posedge clk); #1;
    end
    cnt = 0;
    while (imem_req && cnt < 100) begin
      cnt++;
      @(posedge clk); #1;
    end
    check("timeout_wait_cycles", 32'(cnt), 32'd16);
    check("timeout_fetch_err", 32'(fetch_err), 32'd1);
    check("timeout_imem_req", 32'(imem_req), 32'd0);
    check("timeout_pc", pc, 32'd4);

    // HALT is terminal even if memory becomes ready later.
    repeat (5) @(posedge clk); #1;
    imem_ready = 1'b1;
    repeat (5) @(posedge clk); #1;
    check("halt_imem_req", 32'(imem_req), 32'd0);
    check("halt_exec_en", 32'(exec_en), 32'd0);
    check("halt_fetch_err", 32'(fetch_err), 32'd1);
    check("halt_pc", pc, 32'd4);
    check("fetch_q_drained", 32'(fetch_q.size()), 32'd0);
    check("exec_q_final", 32'(exec_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
